// File: rtl/bus_arb_nxm.sv
// Shared bus for NUM_M masters and NUM_S slaves: registered round-robin arbiter, address decode, read-data return mux; optional hold-timeout under BUS_TIMEOUT_EN.
// Latency: request to grant 1 edge; write/address phase is combinational off the grant; read data and bus_err arrive 1 cycle after the address cycle.
// Backpressure: non-granted masters wait holding m_req; the owner keeps the bus while requesting (until the hold timeout if enabled).
module bus_arb_nxm #(
    parameter int NUM_M    = 2,
    parameter int NUM_S    = 2,
    parameter int AW       = 8,
    parameter int DW       = 32,
    parameter int SLAVE_AW = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_M-1:0]    m_req,
    input  logic [NUM_M-1:0]    m_wr,
    input  logic [NUM_M*AW-1:0] m_address,
    input  logic [NUM_M*DW-1:0] m_dout,
    output logic [NUM_M-1:0]    m_grant,
    output logic [DW-1:0]       m_din,
    output logic                bus_err,
    input  logic [NUM_S*DW-1:0] s_dout,
    output logic [NUM_S-1:0]    s_sel,
    output logic [AW-1:0]       s_address,
    output logic                s_wr,
    output logic [DW-1:0]       s_din
);

    localparam int MW = $clog2(NUM_M);
    localparam int SW = $clog2(NUM_S);
    localparam int IW = AW - SLAVE_AW;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [MW-1:0]    owner_q, owner_d;
    logic [MW-1:0]    rr_q, rr_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [MW-1:0]    start, pick;
    logic [NUM_M-1:0] req_mask;
    logic             found;
    logic             timeout;

    function automatic logic [MW-1:0] wrap_inc(input logic [MW-1:0] v);
        return (int'(v) == NUM_M - 1) ? '0 : v + 1'b1;
    endfunction

    // Owner is masked out so the same search serves both release and timeout handover.
    always_comb begin
        int j;
        j        = 0;
        found    = 1'b0;
        pick     = '0;
        start    = (state_q == OWNED) ? wrap_inc(owner_q) : rr_q;
        req_mask = m_req;
        if (state_q == OWNED)
            req_mask[owner_q] = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            j = int'(start) + i;
            if (j >= NUM_M)
                j = j - NUM_M;
            if (!found && req_mask[j]) begin
                found = 1'b1;
                pick  = MW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWNED;
                    owner_d = pick;
                    rr_d    = wrap_inc(pick);
                end
            end
            OWNED: begin
                if (!m_req[owner_q] || timeout) begin
                    if (found) begin
                        owner_d = pick;
                        rr_d    = wrap_inc(pick);
                    end else if (!m_req[owner_q]) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        grant_d = (state_d == OWNED) ? (NUM_M'(1) << owner_d) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;

    // Counts cycles of one continuous ownership; saturates when nobody else wants the bus.
    always_comb begin
        hold_d = '0;
        if (state_q == OWNED && state_d == OWNED && owner_d == owner_q)
            hold_d = (hold_q == HOLD_LAST) ? hold_q : hold_q + 1'b1;
        timeout = (state_q == OWNED) && (hold_q == HOLD_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            hold_q <= '0;
        else
            hold_q <= hold_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign m_grant = grant_q;

    always_comb begin
        s_address = '0;
        s_wr      = 1'b0;
        s_din     = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (grant_q[k]) begin
                s_address = m_address[k*AW +: AW];
                s_wr      = m_wr[k];
                s_din     = m_dout[k*DW +: DW];
            end
        end
    end

    logic [IW-1:0] idx;
    logic [SW-1:0] sel_idx, rd_idx_q;
    logic          granted, mapped, rd_vld_q, bus_err_q;

    always_comb begin
        idx     = s_address[AW-1:SLAVE_AW];
        granted = |grant_q;
        s_sel   = '0;
        sel_idx = '0;
        mapped  = 1'b0;
        for (int j = 0; j < NUM_S; j++) begin
            if (granted && int'(idx) == j) begin
                s_sel[j] = 1'b1;
                sel_idx  = SW'(j);
                mapped   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            rd_vld_q  <= mapped;
            rd_idx_q  <= sel_idx;
            bus_err_q <= granted && !mapped;
        end
    end

    assign bus_err = bus_err_q;

    always_comb begin
        m_din = '0;
        for (int j = 0; j < NUM_S; j++) begin
            if (rd_vld_q && rd_idx_q == SW'(j))
                m_din = s_dout[j*DW +: DW];
        end
    end

endmodule

// File: tb/tb_bus_arb_nxm.sv
// Bench for bus_arb_nxm (2 masters, 2 slaves); timeout expectations follow BUS_TIMEOUT_EN.
module tb_bus_arb_nxm;

    logic        clk;
    logic        reset_n;
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [15:0] m_address;
    logic [63:0] m_dout;
    logic [1:0]  m_grant;
    logic [31:0] m_din;
    logic        bus_err;
    logic [63:0] s_dout;
    logic [1:0]  s_sel;
    logic [7:0]  s_address;
    logic        s_wr;
    logic [31:0] s_din;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    bus_arb_nxm #(
        .NUM_M(2), .NUM_S(2), .AW(8), .DW(32), .SLAVE_AW(5), .MAX_HOLD(4)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m_req(m_req), .m_wr(m_wr), .m_address(m_address), .m_dout(m_dout),
        .m_grant(m_grant), .m_din(m_din), .bus_err(bus_err),
        .s_dout(s_dout), .s_sel(s_sel), .s_address(s_address),
        .s_wr(s_wr), .s_din(s_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        reset_n = 1'b0;
        m_req   = 2'b00;
        m_wr    = 2'b00;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        m_req     = 2'b11;
        m_wr      = 2'b11;
        m_address = 16'h2121;
        m_dout    = 64'hdead_beef_cafe_f00d;
        s_dout    = 64'h1111_1111_2222_2222;
        tick();
        tick();
        checks++; if (m_grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", m_grant); else passes++;
        checks++; if (s_sel !== 2'b00) $display("FAIL reset_sel: got %b want 00", s_sel); else passes++;
        checks++; if (s_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", s_wr); else passes++;
        checks++; if (s_address !== 8'h00) $display("FAIL reset_addr: got %h want 00", s_address); else passes++;
        checks++; if (s_din !== 32'h0) $display("FAIL reset_din: got %h want 0", s_din); else passes++;
        checks++; if (m_din !== 32'h0) $display("FAIL reset_mdin: got %h want 0", m_din); else passes++;
        checks++; if (bus_err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus_err); else passes++;
    endtask

    task automatic test_write();
        m_req   = 2'b00;
        reset_n = 1'b1;
        m_req   = 2'b10;
        m_wr    = 2'b10;
        m_address[15:8] = 8'h21;
        m_dout[63:32]   = 32'h2100_0000;
        #1;
        checks++; if (m_grant !== 2'b00) $display("FAIL wr_pregrant: got %b want 00", m_grant); else passes++;
        tick();
        checks++; if (m_grant !== 2'b10) $display("FAIL wr_grant: got %b want 10", m_grant); else passes++;
        checks++; if (s_sel !== 2'b10) $display("FAIL wr_sel: got %b want 10", s_sel); else passes++;
        checks++; if (s_wr !== 1'b1) $display("FAIL wr_strobe: got %b want 1", s_wr); else passes++;
        checks++; if (s_din !== 32'h2100_0000) $display("FAIL wr_din: got %h want 21000000", s_din); else passes++;
        checks++; if (s_address !== 8'h21) $display("FAIL wr_addr: got %h want 21", s_address); else passes++;
        m_address[15:8] = 8'h19;
        #1;
        checks++; if (s_sel !== 2'b01) $display("FAIL wr_sel_s0: got %b want 01", s_sel); else passes++;
    endtask

    task automatic test_read();
        exp_t e;
        s_dout = {32'h0000_bbbb, 32'h0000_aaaa};
        m_wr   = 2'b00;
        m_address[15:8] = 8'h22;
        sb.push_back({32'h0000_bbbb, 1'b0});
        #1;
        checks++; if (s_sel !== 2'b10) $display("FAIL rd_sel: got %b want 10", s_sel); else passes++;
        checks++; if (s_wr !== 1'b0) $display("FAIL rd_wr: got %b want 0", s_wr); else passes++;
        tick();
        e = sb.pop_front();
        checks++; if (m_din !== e.dat) $display("FAIL rd_data_s1: got %h want %h", m_din, e.dat); else passes++;
        checks++; if (bus_err !== e.err) $display("FAIL rd_err_s1: got %b want %b", bus_err, e.err); else passes++;
        m_address[15:8] = 8'h55;
        sb.push_back({32'h0, 1'b1});
        #1;
        checks++; if (s_sel !== 2'b00) $display("FAIL unmapped_sel: got %b want 00", s_sel); else passes++;
        tick();
        e = sb.pop_front();
        checks++; if (m_din !== e.dat) $display("FAIL unmapped_data: got %h want %h", m_din, e.dat); else passes++;
        checks++; if (bus_err !== e.err) $display("FAIL unmapped_err: got %b want %b", bus_err, e.err); else passes++;
        m_address[15:8] = 8'h02;
        sb.push_back({32'h0000_aaaa, 1'b0});
        tick();
        e = sb.pop_front();
        checks++; if (m_din !== e.dat) $display("FAIL rd_data_s0: got %h want %h", m_din, e.dat); else passes++;
        checks++; if (bus_err !== e.err) $display("FAIL err_one_cycle: got %b want %b", bus_err, e.err); else passes++;
        m_req = 2'b00;
        tick();
        checks++; if (m_grant !== 2'b00) $display("FAIL release_idle: got %b want 00", m_grant); else passes++;
    endtask

    task automatic test_handover();
        restart();
        m_req = 2'b11;
        tick();
        checks++; if (m_grant !== 2'b01) $display("FAIL tie_m0: got %b want 01", m_grant); else passes++;
        m_req = 2'b10;
        tick();
        checks++; if (m_grant !== 2'b10) $display("FAIL handover_nobubble: got %b want 10", m_grant); else passes++;
    endtask

    task automatic test_fairness();
        int   owner;
        logic [1:0] want;
        owner = 1;
        m_req = 2'b11;
        tick();
        checks++; if (m_grant !== 2'b10) $display("FAIL no_preempt: got %b want 10", m_grant); else passes++;
        for (int i = 0; i < 4; i++) begin
            m_req = (owner == 1) ? 2'b01 : 2'b10;
            want  = (owner == 1) ? 2'b01 : 2'b10;
            tick();
            checks++; if (m_grant !== want) $display("FAIL rr_handover%0d: got %b want %b", i, m_grant, want); else passes++;
            owner = 1 - owner;
            m_req = 2'b11;
        end
    endtask

    task automatic test_timeout();
        logic [1:0] want;
        restart();
        m_req = 2'b11;
        for (int t = 1; t <= 9; t++) begin
            tick();
`ifdef BUS_TIMEOUT_EN
            want = (((t - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
`else
            want = 2'b01;
`endif
            checks++; if (m_grant !== want) $display("FAIL hold_cycle%0d: got %b want %b", t, m_grant, want); else passes++;
        end
    endtask

    task automatic test_reset_mid();
        restart();
        m_req = 2'b10;
        m_wr  = 2'b10;
        m_address[15:8] = 8'h21;
        tick();
        checks++; if (m_grant !== 2'b10) $display("FAIL burst_grant: got %b want 10", m_grant); else passes++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (m_grant !== 2'b00) $display("FAIL async_grant: got %b want 00", m_grant); else passes++;
        checks++; if (s_sel !== 2'b00) $display("FAIL async_sel: got %b want 00", s_sel); else passes++;
        checks++; if (s_wr !== 1'b0) $display("FAIL async_wr: got %b want 0", s_wr); else passes++;
        m_req   = 2'b11;
        m_wr    = 2'b00;
        reset_n = 1'b1;
        tick();
        checks++; if (m_grant !== 2'b01) $display("FAIL post_reset_tie: got %b want 01", m_grant); else passes++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_handover();
        test_fairness();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/bus_arb_nxm.md
# bus_arb_nxm

Parametrised shared-bus interconnect connecting NUM_M masters to NUM_S slaves through one registered round-robin arbiter, one address decoder and one read-data return mux. Next generation of the 2×2 fixed-priority bus: generalised master/slave counts and widths, fair arbitration, an unmapped-address error flag and an optional hold-timeout. It sits between the processor/DMA masters and the memory/peripheral slaves on the single system clock.

## Interface
- NUM_M, 2, number of masters (2..8)
- NUM_S, 2, number of slaves (2..8)
- AW, 8, address width
- DW, 32, data width
- SLAVE_AW, 5, low address bits inside one slave window (window = 2^SLAVE_AW words)
- MAX_HOLD, 16, max consecutive granted cycles under contention (used only with BUS_TIMEOUT_EN)

- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- m_req  in  NUM_M  bus request, one bit per master
- m_wr  in  NUM_M  write strobe per master (1 = write)
- m_address  in  NUM_M*AW  master addresses, master k at [k*AW +: AW]
- m_dout  in  NUM_M*DW  master write data, master k at [k*DW +: DW]
- m_grant  out  NUM_M  one-hot-or-zero grant
- m_din  out  DW  read data returned to all masters
- bus_err  out  1  one-cycle pulse: previous granted cycle hit an unmapped address
- s_dout  in  NUM_S*DW  slave read data, slave j at [j*DW +: DW]
- s_sel  out  NUM_S  one-hot-or-zero slave select
- s_address  out  AW  address from granted master
- s_wr  out  1  write strobe from granted master
- s_din  out  DW  write data from granted master

## Operation
- Arbiter states: IDLE (m_grant = 0) and OWNED(k) (m_grant = 1<<k). Grant is a register.
- IDLE: on each edge, if any m_req, grant the first requester searching from rr_ptr upward (wrapping); else stay IDLE.
- OWNED(k): while m_req[k]=1, keep k (no preemption, except timeout below). When m_req[k]=0, on that edge grant passes directly to the next requester searching from k+1 (wrapping); if none, go IDLE. No idle bubble on handover.
- rr_ptr updates to k+1 (mod NUM_M) whenever master k receives a grant; reset value 0 (master 0 wins first tie).
- Forward path (combinational from m_grant): s_address, s_wr, s_din = granted master's fields; all 0 when IDLE.
- Decode: idx = s_address[AW-1:SLAVE_AW]; if granted and idx < NUM_S, s_sel = 1<<idx; else s_sel = 0.
- Unmapped access (granted, idx >= NUM_S): no s_sel; bus_err=1 on the following cycle; m_din reads 0.
- Read return: rd_idx register captures the decoded slave index (or "none") every edge; m_din = s_dout[rd_idx], 0 when "none".

## Timing
- Reset (async assert): m_grant=0, rr_ptr=0, rd_idx=none, bus_err=0, hold counter=0; therefore s_sel=0, s_address=0, s_wr=0, s_din=0, m_din=0. Reset mid-transfer drops grant immediately, no completion.
- Request-to-grant: 1 edge (req sampled at edge t, grant valid after t).
- Write: s_sel/s_wr/s_address/s_din valid in the same cycle the grant is held; slave captures at the next edge.
- Read: m_din valid one cycle after the address cycle (matches synchronous slave).
- bus_err: registered, high exactly one cycle per unmapped granted cycle.
- Simultaneous requests: resolved by rr_ptr only; ties never split grant.

## Configuration
- BUS_TIMEOUT_EN defined: hold counter counts consecutive cycles of the same owner, cleared on any grant change. When count reaches MAX_HOLD-1 and another master requests, next edge grant moves to the next requester after the owner (RR order) even if owner keeps m_req; owner re-enters RR normally. No other requester → owner keeps grant, counter saturates.
- Not defined: counter absent; owner holds grant indefinitely while requesting.

## Test plan
- Reset, then m_req=2'b10, m1 writes 0x21/0x2100_0000 → m_grant=2'b10 after one edge; s_sel=2'b10, s_wr=1, s_din=0x2100_0000; address 0x19 → s_sel=2'b01.
- m1 read at 0x22 with s1_dout=0x0000_bbbb → m_din=0x0000_bbbb one cycle later; address 0x55 (NUM_S=2) → s_sel=0, bus_err=1 next cycle, m_din=0.
- Both req from reset → m0 granted; m0 drops req while m1 requesting → m1 granted on that edge, no IDLE cycle.
- Both hold req continuously, owners release alternately for 4 handovers → grants alternate m0,m1,m0,m1 (no starvation).
- BUS_TIMEOUT_EN, MAX_HOLD=4, m0 holds req, m1 requests → m0 grant lasts exactly 4 cycles, then m1; without macro m0 keeps grant.
- reset_n low during m1 write burst → m_grant, s_sel, s_wr 0 immediately (asynchronous); after release, m0 wins first tie.
